karatsuba_issue_ctrl: RTL and testbench

KARATSUBA_ISSUE_CTRL -- requirements
Module: karatsuba_issue_ctrl

---
 rtl/karatsuba_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_karatsuba_issue_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_issue_ctrl.sv
// -----------------------------------------------------------------------------
// karatsuba_issue_ctrl
//
// Issue/collect controller wrapped around an iterative (multi-cycle) unsigned
// multiplier. One operand pair is accepted at a time. The operands are latched
// onto the multiplier inputs and the multiplier is held enabled for LAT cycles.
// The product is then captured into an output register and handed downstream
// over a valid/ready handshake. While the product is captured, the multiplier
// is pulsed into reset for one cycle.
//
// Parameters
//   N    : operand width; the product is 2N bits wide
//   LAT  : cycles the multiplier stays enabled per operation (1..255)
//
// Ports
//   clk, rst             : clock and asynchronous active-high reset
//   in_valid / in_ready  : operand handshake; in_ready is high only when idle
//   in_a, in_b           : operands (N bits each)
//   out_valid / out_ready: product handshake
//   out_z                : captured product (2N bits)
//   mul_rst, mul_enable  : control lines of the iterative multiplier
//   mul_a, mul_b         : latched operands presented to the multiplier
//   mul_c                : multiplier result
//   op_count             : number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module karatsuba_issue_ctrl #(
    parameter int N   = 32,
    parameter int LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_z,
    output logic             mul_rst,
    output logic             mul_enable,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_c,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Last counter value of RUN; capture happens on the edge that sees it.
    localparam logic [7:0] LAST_CNT = 8'(LAT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [2*N-1:0]    out_z_q, out_z_d;
    logic              mul_rst_q, mul_rst_d;
    logic              mul_enable_q, mul_enable_d;
    logic [N-1:0]      mul_a_q, mul_a_d;
    logic [N-1:0]      mul_b_q, mul_b_d;
    logic [15:0]       op_count_q, op_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_z_q      <= '0;
            mul_rst_q    <= 1'b1;
            mul_enable_q <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_z_q      <= out_z_d;
            mul_rst_q    <= mul_rst_d;
            mul_enable_q <= mul_enable_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_z_d      = out_z_q;
        // mul_rst is a single-cycle pulse raised only on capture; the first
        // edge after reset also drops it here.
        mul_rst_d    = 1'b0;
        mul_enable_d = mul_enable_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mul_a_d      = in_a;
                    mul_b_d      = in_b;
                    mul_enable_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    out_z_d      = mul_c;
                    out_valid_d  = 1'b1;
                    mul_enable_d = 1'b0;
                    mul_rst_d    = 1'b1;
                    state_d      = CLEAR;
                end
            end
            CLEAR, HOLD: begin
                // CLEAR always leaves after one cycle; it falls into HOLD
                // when downstream is not ready yet.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    state_d     = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_z      = out_z_q;
    assign mul_rst    = mul_rst_q;
    assign mul_enable = mul_enable_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_karatsuba_issue_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for karatsuba_issue_ctrl. A behavioural multiplier model drives
// mul_c and produces the true product only once the multiplier has been
// enabled long enough, so an early or late capture shows up as a wrong value.
// -----------------------------------------------------------------------------
module tb_karatsuba_issue_ctrl;
    localparam int N   = 32;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_z;
    logic           mul_rst;
    logic           mul_enable;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic [2*N-1:0] mul_c;
    logic [15:0]    op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_count;

    karatsuba_issue_ctrl #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .mul_rst(mul_rst), .mul_enable(mul_enable),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Iterative multiplier model: counts enabled cycles since its reset and
    // only shows the real product during the last enabled cycle onwards.
    int mcnt     = 0;
    int en_total = 0;
    always @(posedge clk) begin
        if (mul_rst) mcnt <= 0;
        else if (mul_enable) mcnt <= mcnt + 1;
        if (mul_enable) en_total <= en_total + 1;
    end
    assign mul_c = (mul_enable && mcnt >= LAT - 1)
                 ? ({32'b0, mul_a} * {32'b0, mul_b})
                 : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, run LAT cycles, optionally stall output for
    // 'hold' cycles, then complete the transfer.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble);
        logic [63:0] exp_z;
        int t0_en;
        int waited;
        exp_z  = {32'b0, a} * {32'b0, b};
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        t0_en    = en_total;
        tick();
        in_valid = 1'b0;
        check("mul_a_latched", mul_a, a);
        check("mul_b_latched", mul_b, b);
        check("mul_enable_on", mul_enable, 1);
        check("in_ready_busy", in_ready, 0);
        for (int k = 1; k <= LAT; k++) begin
            if (scramble) begin
                in_a     = $urandom;
                in_b     = $urandom;
                in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            check("out_valid_timing", out_valid, (k == LAT) ? 64'd1 : 64'd0);
            check("mul_a_stable", mul_a, a);
            check("mul_b_stable", mul_b, b);
        end
        in_valid = 1'b0;
        check("out_z", out_z, exp_z);
        check("mul_rst_pulse", mul_rst, 1);
        check("mul_enable_off", mul_enable, 0);
        check("in_ready_clear", in_ready, 0);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("hold_valid", out_valid, 1);
                check("hold_z", out_z, exp_z);
                check("hold_in_ready", in_ready, 0);
                check("hold_mul_rst", mul_rst, 0);
                check("hold_count", op_count, exp_count);
            end
        end
        out_ready = 1'b1;
        tick();
        exp_count++;
        check("xfer_valid_low", out_valid, 0);
        check("xfer_mul_rst", mul_rst, 0);
        check("xfer_in_ready", in_ready, 1);
        check("op_count", op_count, exp_count);
        check("enable_cycles", 64'(en_total - t0_en), LAT);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        exp_count = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_enable", mul_enable, 0);
        check("rst_mul_rst", mul_rst, 1);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_mul_rst_held", mul_rst, 1);
        tick();
        check("post_rst_mul_rst_drop", mul_rst, 0);

        // Single operation
        run_op(32'd10, 32'd12, 0, 1'b0);

        // Sweep
        for (int a = 0; a <= 10; a++) run_op(32'(a), 32'd12, 0, 1'b0);
        check("sweep_count", op_count, 16'd12);

        // Backpressure
        run_op(32'hFFFF_FFFF, 32'd255, 20, 1'b0);

        // Operand/valid noise during RUN, random stalls
        for (int i = 0; i < 8; i++)
            run_op($urandom, $urandom, $urandom_range(0, 3), 1'b1);

        // Reset in the middle of RUN
        in_valid = 1'b1;
        in_a     = 32'd3;
        in_b     = 32'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        exp_count = '0;
        check("midrst_mul_rst", mul_rst, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_count", op_count, 0);
        check("midrst_mul_enable", mul_enable, 0);
        check("midrst_mul_a", mul_a, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        check("midrst_mul_rst_hold", mul_rst, 1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            check("midrst_no_valid", out_valid, 0);
        end
        run_op(32'd7, 32'd9, 0, 1'b0);

        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom, $urandom_range(0, 2), 1'b0);

        // Counter wrap: preload 0xFFFF while idle, then one transfer
        force dut.op_count_q = 16'hFFFF;
        tick();
        release dut.op_count_q;
        #1;
        check("wrap_preload", op_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        run_op(32'd5, 32'd6, 1, 1'b0);
        check("wrap_zero", op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
